// File: rtl/win_check_sequencer.sv
// Move sequencer for the four-direction win checkers.
// Ports: move handshake (move_valid/move_ready/move_pos/move_chess),
//   board RAM (ram_addr/ram_we/ram_wdata/ram_rdata),
//   checker control (chk_reset/chk_active/chk_pointer/chk_chess,
//   chk_addr/chk_success/chk_done), one-cycle result (result_*).
//   reset is asynchronous, active-low.
module win_check_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_valid,
  output logic        move_ready,
  input  logic [7:0]  move_pos,
  input  logic [1:0]  move_chess,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic [1:0]  ram_wdata,
  input  logic [1:0]  ram_rdata,
  output logic        chk_reset,
  output logic [3:0]  chk_active,
  output logic [7:0]  chk_pointer,
  output logic [1:0]  chk_chess,
  input  logic [31:0] chk_addr,
  input  logic [3:0]  chk_success,
  input  logic [3:0]  chk_done,
  output logic        result_valid,
  output logic        result_win,
  output logic [1:0]  result_dir,
  output logic        result_illegal,
  output logic        result_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_CLR,
    S_RUN,
    S_REPORT
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pos;
  logic [1:0] chess;
  logic [1:0] dir;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       live;
  logic       win_q;
  logic       ill_q;
  logic       to_q;
  logic       accept;
  logic       bad;
  logic       hit;
  logic       fin;
  logic       expire;

  assign chk_pointer = pos;
  assign chk_chess   = chess;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    move_ready     = 1'b0;
    ram_addr       = 8'h00;
    ram_we         = 1'b0;
    ram_wdata      = 2'b00;
    chk_reset      = 1'b0;
    chk_active     = 4'b0000;
    result_valid   = 1'b0;
    result_win     = 1'b0;
    result_dir     = 2'b00;
    result_illegal = 1'b0;
    result_timeout = 1'b0;
    cnt_inc        = cnt + 8'd1;
    // live keeps move_ready low while reset is held
    accept         = move_valid && live;
    bad            = (ram_rdata != 2'b00) ||
                     (chess[1] == chess[0]);
    hit            = chk_success[dir];
    fin            = chk_done[dir];
    expire         = (cnt_inc == TO_LIM);
    unique case (state)
      S_IDLE: begin
        move_ready = live;
        if (accept) state_nxt = S_READ;
      end
      S_READ: begin
        ram_addr  = pos;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = bad ? S_REPORT : S_WRITE;
      end
      S_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = pos;
        ram_wdata = chess;
        state_nxt = S_CLR;
      end
      S_CLR: begin
        chk_reset = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        chk_active = 4'b0001 << dir;
        ram_addr   = chk_addr[{dir, 3'b000} +: 8];
        if (hit) begin
          state_nxt = S_REPORT;
        end else if (fin || expire) begin
          state_nxt = (dir == 2'd3) ? S_REPORT : S_CLR;
        end
      end
      S_REPORT: begin
        result_valid   = 1'b1;
        result_win     = win_q;
        result_dir     = win_q ? dir : 2'b00;
        result_illegal = ill_q;
        result_timeout = to_q;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live  <= 1'b0;
      pos   <= 8'h00;
      chess <= 2'b00;
      dir   <= 2'd0;
      cnt   <= 8'h00;
      win_q <= 1'b0;
      ill_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            pos   <= move_pos;
            chess <= move_chess;
            dir   <= 2'd0;
            win_q <= 1'b0;
            ill_q <= 1'b0;
            to_q  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (bad) ill_q <= 1'b1;
        end
        S_CLR: begin
          cnt <= 8'h00;
        end
        S_RUN: begin
          cnt <= cnt_inc;
          if (hit) begin
            win_q <= 1'b1;
          end else if (fin || expire) begin
            // flag only advances forced by the cycle limit
            if (!fin) to_q <= 1'b1;
            if (dir != 2'd3) dir <= dir + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/win_check_sequencer.md
WIN_CHECK_SEQUENCER -- requirements
Module: win_check_sequencer

Interface
REQ-001 Parameter SHALL be: TIMEOUT, 64, maximum RUN cycles per direction before forced advance (legal range 1..255).
REQ-002 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 move_valid  input  1  move offered.
REQ-006 move_ready  output  1  block idle and able to accept a move.
REQ-007 move_pos  input  8  board cell {row[7:4], col[3:0]}.
REQ-008 move_chess  input  2  piece colour: 01 black, 10 white; 00 and 11 are illegal.
REQ-009 ram_addr / ram_we / ram_wdata  output  8/1/2  board RAM port.
REQ-010 ram_rdata  input  2  board RAM read data, valid one cycle after ram_addr.
REQ-011 chk_reset  output  1  active-high reset pulse to the four line checkers.
REQ-012 chk_active  output  4  one-hot checker enable: bit0 horizontal, bit1 vertical, bit2 lean1, bit3 lean2.
REQ-013 chk_pointer / chk_chess  output  8/2  latched move_pos / move_chess driven to all checkers.
REQ-014 chk_addr  input  32  checker d address on bits [8d+7:8d].
REQ-015 chk_success / chk_done  input  4/4  per-checker success and active_next.
REQ-016 result_valid  output  1  one-cycle result pulse.
REQ-017 result_win / result_dir / result_illegal / result_timeout  output  1/2/1/1  result fields, valid while result_valid is high.

Function
REQ-018 FSM states SHALL be IDLE, READ, CHECK, WRITE, CLR, RUN, REPORT.
REQ-019 IDLE: move_ready=1; on move_valid&move_ready, latch move_pos/move_chess, d=0, clear the timeout flag, go to READ.
REQ-020 READ: ram_addr=latched pos, ram_we=0; go to CHECK.
REQ-021 CHECK: if ram_rdata!=00 or chess is 00/11 -> REPORT with illegal=1; else -> WRITE.
REQ-022 WRITE: ram_we=1 for exactly one cycle, ram_addr=pos, ram_wdata=chess; go to CLR.
REQ-023 CLR: chk_reset=1, chk_active=0, timeout counter cleared; go to RUN for the current d.
REQ-024 RUN: chk_active=1<<d, ram_addr=chk_addr[d]; 8-bit counter increments each RUN cycle.
REQ-025 RUN, chk_success[d]=1: go to REPORT with win=1, dir=d; success takes priority over chk_done[d] asserted in the same cycle.
REQ-026 RUN, chk_done[d]=1 (no success) or counter reaching TIMEOUT: if d<3 then d=d+1 -> CLR; if d==3 -> REPORT with win=0.
REQ-027 A TIMEOUT-forced advance SHALL set the sticky timeout flag, reported as result_timeout.
REQ-028 Inputs of the non-selected checkers SHALL be ignored.
REQ-029 REPORT: result_valid=1 for one cycle; go to IDLE. result_dir=0 whenever win=0.
REQ-030 move_ready SHALL be 0 in every state except IDLE; move_valid outside IDLE SHALL be ignored.
REQ-031 ram_we SHALL be high only in WRITE.
REQ-032 Best-case latency (no illegal move, win in dir 0 after k RUN cycles) SHALL be 4+k+1 cycles from accept to result_valid.

Reset
REQ-033 While reset=0, the block SHALL go to IDLE with d=0 and the counter and flags cleared.
REQ-034 While reset=0: move_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, chk_reset=0, chk_active=0, chk_pointer=0, chk_chess=0, and all result_* outputs 0.
REQ-035 Reset deassertion SHALL take effect on the next clk edge; a move in progress SHALL be abandoned with no result pulse.
REQ-036 move_ready SHALL be 1 on the first cycle after reset is released.

Verification
REQ-037 Win, dir 0: pos=8'h37, chess=01, rdata=00, chk_success[0] on 6th RUN cycle -> one ram_we pulse (addr 37, data 01), then result_valid with win=1, dir=0, illegal=0.
REQ-038 Occupied cell: pos=8'h37, rdata=10 -> no ram_we, no chk_reset, result_valid with illegal=1, win=0.
REQ-039 No win: all four checkers assert only done -> four chk_reset pulses, chk_active walks 0001,0010,0100,1000, then result win=0, dir=0.
REQ-040 Simultaneous events: success[2] and done[2] in the same cycle -> win=1, dir=2, and chk_active never reaches 1000.
REQ-041 Timeout: TIMEOUT=8, checker 1 silent -> advance to d=2 after 8 RUN cycles, final result has timeout=1.
REQ-042 Reset mid-RUN (d=1): all outputs 0 during reset, no result_valid, move_ready=1 after release.
